i2s_dac_transmitter: RTL and testbench

//  Parallel-to-serial I2S transmitter for the WM8731 DAC path on DE2-115; the codec is the BCLK/LRCK master.

---
 rtl/audio_pkg.sv | 7 +
 rtl/audio_edge_sync.sv | 26 ++
 rtl/i2s_dac_transmitter.sv | 94 +++++++++
 tb/tb_i2s_dac_transmitter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample width, I2S transmitter state encodings and LRCK polarity for the codec path
package audio_pkg;
  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam logic LEFT = 1'b0;
  localparam logic RIGHT = 1'b1;
  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} i2s_state_e;
endpackage

// File: rtl/audio_edge_sync.sv
// audio_edge_sync: multi-flop synchronizer plus history flop giving level and one-clk edge strobes
module audio_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic hist_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end
  assign level_o = sync_q[STAGES-1];
  assign rise_o = ~hist_q & level_o;
  assign fall_o = hist_q & ~level_o;
endmodule

// File: rtl/i2s_dac_transmitter.sv
// i2s_dac_transmitter: stereo word to MSB-first I2S serial data, with BCLK/LRCK from the codec oversampled in clk
module i2s_dac_transmitter
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = audio_pkg::DEF_SAMPLE_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_DELAY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      AUD_BCLK,
  input  logic                      AUD_DACLRCK,
  input  logic [2*SAMPLE_WIDTH-1:0] audioIn,
  input  logic                      audio_valid,
  output logic                      sample_req,
  output logic                      underrun,
  output logic                      AUD_DACDAT
);
  localparam int W = SAMPLE_WIDTH;
  localparam int CW = $clog2(W + 1);
  logic bclk_lvl, bclk_rise, bclk_fall, lrck, lrck_rise, lrck_fall, unused_sync;
  logic lrck_prev_q, lrck_edge, latch;
  logic [W-1:0] shreg_q, shreg_d, hold_q, hold_d, word;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic dat_q, dat_d, req_q, req_d, und_q, und_d;
  i2s_state_e state_q, state_d;

  audio_edge_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk(clk), .rst(rst), .d_i(AUD_BCLK),
    .level_o(bclk_lvl), .rise_o(bclk_rise), .fall_o(bclk_fall)
  );
  audio_edge_sync #(.STAGES(SYNC_STAGES)) u_lrck_sync (
    .clk(clk), .rst(rst), .d_i(AUD_DACLRCK),
    .level_o(lrck), .rise_o(lrck_rise), .fall_o(lrck_fall)
  );
  assign unused_sync = ^{bclk_lvl, bclk_rise, lrck_rise, lrck_fall};

  assign lrck_edge = bclk_fall && (lrck != lrck_prev_q);
  assign latch = lrck_edge && (lrck == LEFT);
  // the right half always replays the held word so both channels belong to one frame
  assign word = (lrck == RIGHT) ? hold_q : (audio_valid ? audioIn[2*W-1:W] : '0);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    hold_d = hold_q;
    bit_cnt_d = bit_cnt_q;
    dat_d = dat_q;
    req_d = latch;
    und_d = latch && !audio_valid;
    if (latch) hold_d = audio_valid ? audioIn[W-1:0] : '0;
    if (lrck_edge && (state_q != IDLE || latch)) begin
      state_d = (DATA_DELAY == 0) ? SHIFT : DELAY;
      shreg_d = (DATA_DELAY == 0) ? (word << 1) : word;
      bit_cnt_d = (DATA_DELAY == 0) ? CW'(1) : '0;
      dat_d = (DATA_DELAY == 0) ? word[W-1] : dat_q;
    end else if (bclk_fall) begin
      if (state_q == DELAY || state_q == SHIFT) begin
        dat_d = shreg_q[W-1];
        shreg_d = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d = (bit_cnt_q == CW'(W - 1)) ? PAD : SHIFT;
      end else begin
        dat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      hold_q <= '0;
      bit_cnt_q <= '0;
      dat_q <= 1'b0;
      req_q <= 1'b0;
      und_q <= 1'b0;
      lrck_prev_q <= LEFT;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      hold_q <= hold_d;
      bit_cnt_q <= bit_cnt_d;
      dat_q <= dat_d;
      req_q <= req_d;
      und_q <= und_d;
      if (bclk_fall) lrck_prev_q <= lrck;
    end
  end

  assign AUD_DACDAT = dat_q;
  assign sample_req = req_q;
  assign underrun = und_q;
endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// tb_i2s_dac_transmitter: codec-side BCLK/LRCK generator, reference I2S decoder and frame scoreboard
module tb_i2s_dac_transmitter;
  typedef struct {int frame; logic [15:0] word;} exp_t;
  logic clk = 1'b0, rst = 1'b1, bclk = 1'b1, lrck = 1'b1, valid = 1'b0;
  logic [31:0] audio = '0;
  logic req, und, dac, req_lj, und_lj, dac_lj;
  int half_len = 32, gen_frame = 0, vectors = 0, errors = 0;
  int req_cnt = 0, und_cnt = 0, req_lj_cnt = 0, und_lj_cnt = 0, wide = 0;
  logic req_prev = 1'b0, dec_lr = 1'b1, bit_v;
  int dd;
  exp_t q[$];
  bit en[2] = '{1'b0, 1'b0};
  int d_idx[2], d_nb[2], d_pad[2], d_fr[2];
  logic [15:0] d_word[2];

  i2s_dac_transmitter dut (
    .clk(clk), .rst(rst), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .audioIn(audio),
    .audio_valid(valid), .sample_req(req), .underrun(und), .AUD_DACDAT(dac)
  );
  i2s_dac_transmitter #(.DATA_DELAY(0)) dut_lj (
    .clk(clk), .rst(rst), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .audioIn(32'h8001_8001),
    .audio_valid(1'b1), .sample_req(req_lj), .underrun(und_lj), .AUD_DACDAT(dac_lj)
  );

  always #10 clk = ~clk;

  // codec master: BCLK = clk/16, LRCK toggles on a BCLK falling edge every half_len BCLKs
  initial begin
    int bcnt = 0;
    forever begin
      repeat (8) @(negedge clk);
      bclk = 1'b0;
      bcnt++;
      if (bcnt >= half_len) begin
        bcnt = 0;
        lrck = ~lrck;
        if (lrck == 1'b0) gen_frame++;
      end
      repeat (8) @(negedge clk);
      bclk = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (req) req_cnt++;
    if (und) und_cnt++;
    if (req_lj) req_lj_cnt++;
    if (und_lj) und_lj_cnt++;
    if (req && req_prev) wide++;
    req_prev = req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic finish_half(input int k);
    logic [31:0] m32;
    logic [15:0] m;
    exp_t e;
    if (!en[k] || d_nb[k] == 0) return;
    m32 = 32'hFFFF << (16 - d_nb[k]);
    m = m32[15:0];
    if (k == 1) begin
      chk("lj_word", {16'h0, d_word[1]}, {16'h0, 16'h8001 & m});
      chk("lj_pad", d_pad[1], 0);
      return;
    end
    while (q.size() != 0 && q[0].frame < d_fr[0]) begin
      e = q.pop_front();
      chk("missed_frame", d_fr[0], e.frame);
    end
    if (q.size() != 0 && q[0].frame == d_fr[0]) begin
      e = q.pop_front();
      chk("word", {16'h0, d_word[0]}, {16'h0, e.word & m});
      chk("pad", d_pad[0], 0);
    end
  endtask

  // reference decoder: samples DACDAT on BCLK rising edges like the codec
  always @(posedge bclk) begin
    if (lrck !== dec_lr) begin
      finish_half(0);
      finish_half(1);
      dec_lr = lrck;
      for (int k = 0; k < 2; k++) begin
        d_idx[k] = 0; d_nb[k] = 0; d_pad[k] = 0; d_word[k] = '0; d_fr[k] = gen_frame;
      end
    end
    for (int k = 0; k < 2; k++) begin
      bit_v = (k == 0) ? dac : dac_lj;
      dd = (k == 0) ? 1 : 0;
      if (d_idx[k] >= dd && d_idx[k] < dd + 16) begin
        d_word[k][15 - (d_idx[k] - dd)] = bit_v;
        d_nb[k]++;
      end else if (d_idx[k] >= dd + 16 && bit_v) d_pad[k]++;
      d_idx[k]++;
    end
  end

  task automatic push(input int f);
    q.push_back('{frame: f, word: valid ? audio[31:16] : 16'h0});
    q.push_back('{frame: f, word: valid ? audio[15:0] : 16'h0});
  endtask

  task automatic wait_req(input logic exp_und);
    int n = 0;
    while (req !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("req_timeout", {31'h0, n < 4000}, 1);
    chk("und_with_req", {31'h0, und}, {31'h0, exp_und});
    @(negedge clk);
  endtask

  initial begin
    int r0, rl0, f0, n, bad;
    logic seen;
    repeat (5) @(negedge clk);
    chk("rst_dac", {31'h0, dac}, 0);
    chk("rst_req", {31'h0, req}, 0);
    chk("rst_und", {31'h0, und}, 0);
    rst = 1'b0;
    en[0] = 1'b1;
    valid = 1'b1;
    audio = 32'hA5A5_3C3C;
    push(gen_frame + 1);
    wait_req(1'b0);
    repeat (2) @(negedge clk);
    r0 = req_cnt; rl0 = req_lj_cnt; f0 = gen_frame;
    push(gen_frame + 1);
    repeat (20) @(negedge clk);
    en[1] = 1'b1;
    wait_req(1'b0);
    repeat (200) @(negedge clk);
    audio = 32'h1234_5678;
    push(gen_frame + 1);
    wait_req(1'b0);
    valid = 1'b0;
    push(gen_frame + 1);
    wait_req(1'b1);
    valid = 1'b1;
    audio = 32'hC0DE_7E57;
    push(gen_frame + 1);
    half_len = 10;
    wait_req(1'b0);
    audio = 32'hDEAD_BEEF;
    push(gen_frame + 1);
    wait_req(1'b0);
    half_len = 64;
    audio = 32'h8421_FFFF;
    push(gen_frame + 1);
    wait_req(1'b0);
    half_len = 32;
    audio = 32'hFFFF_F00F;
    push(gen_frame + 1);
    wait_req(1'b0);
    repeat (2) @(negedge clk);
    chk("req_per_frame", req_cnt - r0, gen_frame - f0);
    chk("lj_req_per_frame", req_lj_cnt - rl0, gen_frame - f0);
    repeat (100) @(negedge clk);
    en[0] = 1'b0;
    en[1] = 1'b0;
    q.delete();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_dac", {31'h0, dac}, 0);
      chk("rst_mid_req", {31'h0, req}, 0);
      chk("rst_mid_und", {31'h0, und}, 0);
    end
    rst = 1'b0;
    n = 0; bad = 0; seen = 1'b0;
    while (lrck !== 1'b1 && n < 3000) begin
      @(negedge clk); n++;
      if (dac !== 1'b0) bad++;
    end
    while (lrck !== 1'b0 && n < 3000) begin
      @(negedge clk); n++;
      if (dac !== 1'b0) bad++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dac !== 1'b0) bad++;
      if (req === 1'b1) seen = 1'b1;
    end
    chk("lrck_timeout", {31'h0, n < 3000}, 1);
    chk("post_rst_silent", bad, 0);
    chk("post_rst_req", {31'h0, seen}, 1);
    en[0] = 1'b1;
    push(gen_frame);
    push(gen_frame + 1);
    wait_req(1'b0);
    repeat (20) @(negedge clk);
    en[1] = 1'b1;
    audio = 32'h0F0F_5A5A;
    push(gen_frame + 1);
    wait_req(1'b0);
    n = 0;
    while (q.size() != 0 && n < 4000) begin
      @(negedge clk); n++;
    end
    chk("drain", q.size(), 0);
    chk("wide_req", wide, 0);
    chk("und_total", und_cnt, 1);
    chk("lj_und", und_lj_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
